// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (IF) and data (D).
// One access is in flight at a time; completion is signalled by a one-cycle ack after MEM_LAT cycles.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    // Countdown is 4 bits wide, so MEM_LAT must stay within 1..15.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_q, sel_d;     // granted port: 1 = D, 0 = IF
    logic              last_q, last_d;   // port of the previous grant
    logic              we_q, we_d;
    logic              grant;
    logic              capture;

    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            we_q        <= we_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        we_d    = we_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant   = 1'b1;
                    // On a tie the port that did not win last time is served.
                    sel_d   = d_req && !(if_req && last_q);
                    last_d  = sel_d;
                    we_d    = sel_d && d_we;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed one cycle early so that every port comes straight from a flop.
    always_comb begin
        mem_en_d    = (state_d == ISSUE);
        mem_we_d    = (state_d == ISSUE) && we_d;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant) begin
            mem_addr_d = sel_d ? d_addr : if_addr;
            if (sel_d) begin
                mem_wdata_d = d_wdata;
            end
        end
        capture    = (state_q == WAIT) && (cnt_q == 4'd1);
        if_ack_d   = capture && !sel_q;
        d_ack_d    = capture && sel_q;
        if_rdata_d = if_ack_d ? mem_rdata : if_rdata_q;
        d_rdata_d  = (d_ack_d && !we_q) ? mem_rdata : d_rdata_q;
        busy_d     = (state_d != IDLE);
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random IF/D traffic, checked cycle by cycle
// against a transaction-level schedule and a shadow copy of memory.
module tb_mem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          if_req  = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          if_ack, d_ack, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 16) return 16'h1234;
        if (i == 5)  return 16'h00AB;
        return 16'((i * 1105) ^ 16'h3C96);
    endfunction

    // Memory seen by the DUT: indexed by the low address byte, read data appears LAT cycles after mem_en.
    logic [DW-1:0] mem_arr [0:255];
    logic [DW-1:0] rd_pipe [0:15];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[7:0]] : 16'hDEAD;
        for (int i = 1; i < 16; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference model state
    logic [DW-1:0] shadow [0:255];
    int            cyc, next_idle, en_cyc, ack_cyc, n_txn;
    bit            lg_d;
    bit            g_d;
    logic          g_we;
    logic [AW-1:0] g_addr, exp_mem_addr;
    logic [DW-1:0] g_wdata, g_rexp, exp_if_rdata, exp_d_rdata;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        en_cyc       = -1;
        ack_cyc      = -1;
        lg_d         = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        exp_mem_addr = '0;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_en"},   32'(mem_en),    32'd0);
        chk({tag, "_mem_we"},   32'(mem_we),    32'd0);
        chk({tag, "_busy"},     32'(busy),      32'd0);
        chk({tag, "_if_ack"},   32'(if_ack),    32'd0);
        chk({tag, "_d_ack"},    32'(d_ack),     32'd0);
        chk({tag, "_if_rdata"}, 32'(if_rdata),  32'd0);
        chk({tag, "_d_rdata"},  32'(d_rdata),   32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"},32'(mem_wdata), 32'd0);
    endtask

    task automatic req_if(input logic [AW-1:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic req_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = w;
    endtask

    // Schedule a grant for the requests driven in the current cycle if the arbiter is free.
    task automatic decide();
        if (cyc >= next_idle && (if_req || d_req)) begin
            if (if_req && d_req) g_d = lg_d ? 1'b0 : 1'b1;
            else                 g_d = d_req;
            lg_d    = g_d;
            g_we    = g_d ? d_we : 1'b0;
            g_addr  = g_d ? d_addr : if_addr;
            g_wdata = d_wdata;
            if (g_we) shadow[g_addr[7:0]] = g_wdata;
            else      g_rexp = shadow[g_addr[7:0]];
            en_cyc    = cyc + 1;
            ack_cyc   = cyc + 2 + LAT;
            next_idle = cyc + LAT + 3;
        end
    endtask

    task automatic tick();
        logic exp_en;
        @(posedge clk);
        #1;
        cyc++;
        exp_en = (cyc == en_cyc);
        if (exp_en) exp_mem_addr = g_addr;
        if (cyc == ack_cyc) begin
            if (!g_d)      exp_if_rdata = g_rexp;
            else if (!g_we) exp_d_rdata = g_rexp;
        end
        chk("mem_en",   32'(mem_en),   32'(exp_en));
        chk("mem_we",   32'(mem_we),   32'(exp_en && g_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
        if (exp_en && g_we) chk("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
        chk("busy",     32'(busy),     32'(cyc >= en_cyc && cyc <= ack_cyc));
        chk("if_ack",   32'(if_ack),   32'(cyc == ack_cyc && !g_d));
        chk("d_ack",    32'(d_ack),    32'(cyc == ack_cyc && g_d));
        chk("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
        chk("d_rdata",  32'(d_rdata),  32'(exp_d_rdata));
        if (cyc == ack_cyc) begin
            n_txn++;
            $display("txn %0d cycle %0d: %s %s addr=%h data=%h", n_txn, cyc,
                     g_d ? "D " : "IF", g_we ? "wr" : "rd", g_addr, g_we ? g_wdata : g_rexp);
            if (g_d) d_req = 1'b0;
            else     if_req = 1'b0;
        end
    endtask

    task automatic run(input int n, input int p_if, input int p_d);
        repeat (n) begin
            tick();
            if (!if_req && int'($urandom_range(99)) < p_if) req_if(16'($urandom));
            if (!d_req && int'($urandom_range(99)) < p_d)
                req_d(1'($urandom), 16'($urandom), 16'($urandom));
            decide();
        end
    endtask

    initial begin
        cyc       = 0;
        next_idle = 0;
        n_txn     = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single IF read of a preloaded word
        req_if(16'h0010);
        decide();
        run(8, 0, 0);

        // D write, then IF read of the same address
        tick(); req_d(1'b1, 16'h0020, 16'hBEEF); decide();
        run(8, 0, 0);
        tick(); req_if(16'h0020); decide();
        run(8, 0, 0);

        // D read of a preloaded word
        tick(); req_d(1'b0, 16'h0005, 16'h0000); decide();
        run(8, 0, 0);

        // Simultaneous requests after a D grant: IF first, then D
        tick(); req_if(16'h0040); req_d(1'b0, 16'h0041, 16'h0000); decide();
        run(14, 0, 0);

        // Both ports kept requesting: strict alternation at MEM_LAT+3 spacing
        run(8 * (LAT + 3) + 4, 100, 100);
        run(20, 0, 0);

        // Random mixed traffic
        run(1500, 30, 30);
        run(20, 0, 0);

        // Asynchronous reset while an IF read is waiting on memory
        tick(); req_if(16'h0077); decide();
        tick(); tick();
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        #1;
        rst = 1'b0;
        cyc++;
        next_idle = cyc;
        decide();
        run(12, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
